// File: rtl/spi_des_cmd_frontend.sv
// SPI command front-end for the fixed-key DES engine: decodes ENC/DEC/READ/STATUS frames, all in the SCK domain.
// Build macro SPI_DES_CMD_CHECKSUM_EN adds a trailing XOR checksum byte to ENC/DEC frames and READ replies.
module spi_des_cmd_frontend #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter logic [3:0]  STATUS_ID  = 4'h5
) (
  input  logic                  SCK,
  input  logic                  RST_N,
  input  logic                  CS_N,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic                  busy_in,
  input  logic                  done_in,
  input  logic [DATA_WIDTH-1:0] result_in,
  output logic [DATA_WIDTH-1:0] text_out,
  output logic                  start,
  output logic                  encrypt_ndecrypt,
  output logic                  frame_err
);

  localparam logic [7:0] CMD_ENC    = 8'hE0;
  localparam logic [7:0] CMD_DEC    = 8'hD0;
  localparam logic [7:0] CMD_READ   = 8'hA0;
  localparam logic [7:0] CMD_STATUS = 8'h50;

`ifdef SPI_DES_CMD_CHECKSUM_EN
  localparam int unsigned CSUM_BITS = 8;
`else
  localparam int unsigned CSUM_BITS = 0;
`endif
  localparam int unsigned FRAME_BITS = 8 + DATA_WIDTH + CSUM_BITS;
  localparam int unsigned RD_W       = DATA_WIDTH + CSUM_BITS;
  localparam int unsigned CW         = $clog2(FRAME_BITS + 1);

  localparam logic [CW-1:0] CNT_CMD_LAST   = CW'(7);
  localparam logic [CW-1:0] CNT_DATA_FIRST = CW'(8);
  localparam logic [CW-1:0] CNT_DATA_LAST  = CW'(7 + DATA_WIDTH);
  localparam logic [CW-1:0] CNT_RD_LAST    = CW'(6 + RD_W);
  localparam logic [CW-1:0] CNT_ST_LAST    = CW'(14);
  localparam logic [CW-1:0] CNT_SAT        = CW'(FRAME_BITS);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] text_q, text_d;
  logic                  enc_q, enc_d;
  logic                  start_q, start_d;
  logic                  miso_q, miso_d;
  logic [RD_W-1:0]       rd_sh_q, rd_sh_d;
  logic [7:0]            st_sh_q, st_sh_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  rv_q, rv_d;
  logic                  rd_done_q, rd_done_d;
  logic                  ovr_q, ovr_d;
  logic                  ferr_q, ferr_d;

  logic [7:0]            cmd_full;
  logic [DATA_WIDTH-1:0] data_full;
  logic [RD_W-1:0]       rd_word;
  logic                  is_xfer;

  assign cmd_full  = {cmd_q[6:0], MOSI};
  assign data_full = {data_q[DATA_WIDTH-2:0], MOSI};
  assign is_xfer   = (cmd_q == CMD_ENC) || (cmd_q == CMD_DEC);

`ifdef SPI_DES_CMD_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic [7:0] csum_full;
  assign csum_full = {csum_q[6:0], MOSI};

  function automatic logic [7:0] xor_bytes(input logic [DATA_WIDTH-1:0] v);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < int'(DATA_WIDTH / 8); i++) acc = acc ^ v[i*8 +: 8];
    return acc;
  endfunction

  assign rd_word = {result_q, xor_bytes(result_q)};
`else
  assign rd_word = result_q;
`endif

  always_comb begin
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    text_d    = text_q;
    enc_d     = enc_q;
    start_d   = 1'b0;
    miso_d    = 1'b0;
    rd_sh_d   = rd_sh_q;
    st_sh_d   = st_sh_q;
    result_d  = result_q;
    rv_d      = rv_q;
    rd_done_d = rd_done_q;
    ovr_d     = ovr_q;
    ferr_d    = ferr_q;
`ifdef SPI_DES_CMD_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    if (CS_N) begin
      cnt_d = '0;
      cmd_d = '0;
    end else begin
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
      if (cnt_q <= CNT_CMD_LAST) cmd_d = cmd_full;

      // The reply's first bit is already on MISO for the slot after the command byte.
      if (cnt_q == CNT_CMD_LAST) begin
        case (cmd_full)
          CMD_ENC, CMD_DEC: ;
          CMD_READ: begin
            rd_sh_d   = {rd_word[RD_W-2:0], 1'b0};
            miso_d    = rd_word[RD_W-1];
            rd_done_d = 1'b0;
          end
          CMD_STATUS: begin
            st_sh_d = {rv_q, ovr_q, ferr_q, STATUS_ID, 1'b0};
            miso_d  = busy_in;
          end
          default: ferr_d = 1'b1;
        endcase
      end

      if (cnt_q >= CNT_DATA_FIRST && cnt_q <= CNT_DATA_LAST) data_d = data_full;

      if (cmd_q == CMD_READ && cnt_q >= CNT_DATA_FIRST && cnt_q <= CNT_RD_LAST) begin
        miso_d  = rd_sh_q[RD_W-1];
        rd_sh_d = {rd_sh_q[RD_W-2:0], 1'b0};
        if (cnt_q == CNT_RD_LAST && !rd_done_q) rv_d = 1'b0;
      end

      if (cmd_q == CMD_STATUS && cnt_q >= CNT_DATA_FIRST && cnt_q <= CNT_ST_LAST) begin
        miso_d  = st_sh_q[7];
        st_sh_d = {st_sh_q[6:0], 1'b0};
        if (cnt_q == CNT_ST_LAST) begin
          ovr_d  = 1'b0;
          ferr_d = 1'b0;
        end
      end

`ifdef SPI_DES_CMD_CHECKSUM_EN
      if (cnt_q > CNT_DATA_LAST && cnt_q < CNT_SAT) csum_d = csum_full;
      if (is_xfer && cnt_q == CNT_SAT - 1'b1) begin
        if (xor_bytes(data_q) != csum_full) begin
          ferr_d = 1'b1;
        end else if (busy_in) begin
          ovr_d = 1'b1;
        end else begin
          text_d  = data_q;
          enc_d   = (cmd_q == CMD_ENC);
          start_d = 1'b1;
        end
      end
`else
      if (is_xfer && cnt_q == CNT_DATA_LAST) begin
        if (busy_in) begin
          ovr_d = 1'b1;
        end else begin
          text_d  = data_full;
          enc_d   = (cmd_q == CMD_ENC);
          start_d = 1'b1;
        end
      end
`endif
    end

    // A result landing mid-read marks itself so the read's end does not drop it.
    if (done_in) begin
      result_d  = result_in;
      rv_d      = 1'b1;
      rd_done_d = 1'b1;
    end
  end

  always_ff @(posedge SCK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q     <= '0;
      cmd_q     <= '0;
      data_q    <= '0;
      text_q    <= '0;
      enc_q     <= 1'b0;
      start_q   <= 1'b0;
      miso_q    <= 1'b0;
      rd_sh_q   <= '0;
      st_sh_q   <= '0;
      result_q  <= '0;
      rv_q      <= 1'b0;
      rd_done_q <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef SPI_DES_CMD_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      text_q    <= text_d;
      enc_q     <= enc_d;
      start_q   <= start_d;
      miso_q    <= miso_d;
      rd_sh_q   <= rd_sh_d;
      st_sh_q   <= st_sh_d;
      result_q  <= result_d;
      rv_q      <= rv_d;
      rd_done_q <= rd_done_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
`ifdef SPI_DES_CMD_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign MISO             = miso_q;
  assign text_out         = text_q;
  assign start            = start_q;
  assign encrypt_ndecrypt = enc_q;
  assign frame_err        = ferr_q;

endmodule

// File: tb/tb_spi_des_cmd_frontend.sv
// Directed bench for spi_des_cmd_frontend (default build): host drives on SCK falling edges and samples MISO there.
module tb_spi_des_cmd_frontend;

  localparam int DW = 64;
  localparam logic [63:0] R_A = 64'h0F1E2D3C4B5A6978;
  localparam logic [63:0] R_B = 64'hA5A50000FFFF1234;
  localparam logic [63:0] R_C = 64'h13579BDF02468ACE;

  logic          SCK       = 1'b0;
  logic          RST_N     = 1'b0;
  logic          CS_N      = 1'b1;
  logic          MOSI      = 1'b0;
  logic          busy_in   = 1'b0;
  logic          done_in   = 1'b0;
  logic [DW-1:0] result_in = '0;
  logic          MISO;
  logic [DW-1:0] text_out;
  logic          start;
  logic          encrypt_ndecrypt;
  logic          frame_err;

  int tests     = 0;
  int fails     = 0;
  int start_cnt = 0;

  spi_des_cmd_frontend #(.DATA_WIDTH(DW), .STATUS_ID(4'h5)) dut (
    .SCK(SCK), .RST_N(RST_N), .CS_N(CS_N), .MOSI(MOSI), .MISO(MISO),
    .busy_in(busy_in), .done_in(done_in), .result_in(result_in),
    .text_out(text_out), .start(start), .encrypt_ndecrypt(encrypt_ndecrypt),
    .frame_err(frame_err)
  );

  always #5 SCK = ~SCK;

  always @(negedge SCK) if (start) start_cnt++;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge SCK);
  endtask

  // cap[71-k] holds MISO as seen by the host during bit slot k.
  task automatic frame(input logic [7:0] cmd, input logic [63:0] data, input int nbits,
                       input int done_at, input logic [63:0] done_val,
                       output logic [71:0] cap, output logic start_end);
    logic [71:0] bits;
    bits = {cmd, data};
    cap  = '0;
    for (int k = 0; k < nbits; k++) begin
      @(negedge SCK);
      cap[71-k] = MISO;
      CS_N      = 1'b0;
      MOSI      = bits[71-k];
      done_in   = (k == done_at);
      if (k == done_at) result_in = done_val;
    end
    @(negedge SCK);
    start_end = start;
    CS_N      = 1'b1;
    MOSI      = 1'b0;
    done_in   = 1'b0;
  endtask

  task automatic pulse_done(input logic [63:0] v);
    @(negedge SCK);
    done_in   = 1'b1;
    result_in = v;
    @(negedge SCK);
    done_in   = 1'b0;
  endtask

  initial begin
    logic [71:0] cap;
    logic        st_end;
    int          sc;

    // Reset
    idle(3);
    check("rst_miso", 72'(MISO), 72'd0);
    check("rst_start", 72'(start), 72'd0);
    check("rst_text", 72'(text_out), 72'd0);
    check("rst_enc", 72'(encrypt_ndecrypt), 72'd0);
    check("rst_ferr", 72'(frame_err), 72'd0);
    RST_N = 1'b1;
    idle(2);

    // 1: ENC accepted
    sc = start_cnt;
    frame(8'hE0, 64'h0123456789ABCDEF, 72, -1, 64'd0, cap, st_end);
    check("t1_start_after_bit71", 72'(st_end), 72'd1);
    idle(3);
    check("t1_start_cycles", 72'(start_cnt - sc), 72'd1);
    check("t1_text", 72'(text_out), 72'h0123456789ABCDEF);
    check("t1_enc", 72'(encrypt_ndecrypt), 72'd1);

    // 2: READ result, then STATUS shows result_valid cleared
    pulse_done(64'h85E813540F0AB405);
    idle(2);
    sc = start_cnt;
    frame(8'hA0, 64'd0, 72, -1, 64'd0, cap, st_end);
    check("t2_read_data", 72'(cap[63:0]), 72'h85E813540F0AB405);
    check("t2_read_cmd_slots", 72'(cap[71:64]), 72'd0);
    idle(2);
    check("t2_no_start", 72'(start_cnt - sc), 72'd0);
    frame(8'h50, 64'd0, 72, -1, 64'd0, cap, st_end);
    check("t2_status", 72'(cap[63:56]), 72'h05);
    check("t2_status_tail", 72'(cap[55:0]), 72'd0);
    idle(2);

    // 3: DEC while busy -> overrun
    busy_in = 1'b1;
    sc = start_cnt;
    frame(8'hD0, 64'h1122334455667788, 72, -1, 64'd0, cap, st_end);
    idle(3);
    check("t3_no_start", 72'(start_cnt - sc), 72'd0);
    check("t3_text_hold", 72'(text_out), 72'h0123456789ABCDEF);
    frame(8'h50, 64'd0, 72, -1, 64'd0, cap, st_end);
    check("t3_status1", 72'(cap[63:56]), 72'hA5);
    idle(2);
    frame(8'h50, 64'd0, 72, -1, 64'd0, cap, st_end);
    check("t3_status2", 72'(cap[63:56]), 72'h85);
    busy_in = 1'b0;
    idle(2);

    // 4: aborted ENC, then a full DEC
    sc = start_cnt;
    frame(8'hE0, 64'hFFFF0000AAAA5555, 40, -1, 64'd0, cap, st_end);
    idle(3);
    check("t4_abort_no_start", 72'(start_cnt - sc), 72'd0);
    check("t4_abort_text_hold", 72'(text_out), 72'h0123456789ABCDEF);
    sc = start_cnt;
    frame(8'hD0, 64'hDEADBEEFCAFEF00D, 72, -1, 64'd0, cap, st_end);
    idle(3);
    check("t4_dec_start", 72'(start_cnt - sc), 72'd1);
    check("t4_dec_text", 72'(text_out), 72'hDEADBEEFCAFEF00D);
    check("t4_dec_enc", 72'(encrypt_ndecrypt), 72'd0);

    // 5: unknown command
    sc = start_cnt;
    frame(8'h33, 64'hFFFFFFFFFFFFFFFF, 72, -1, 64'd0, cap, st_end);
    idle(2);
    check("t5_miso_zero", cap, 72'd0);
    check("t5_ferr_set", 72'(frame_err), 72'd1);
    check("t5_no_start", 72'(start_cnt - sc), 72'd0);
    frame(8'h50, 64'd0, 72, -1, 64'd0, cap, st_end);
    check("t5_status", 72'(cap[63:56]), 72'h15);
    idle(1);
    check("t5_ferr_cleared", 72'(frame_err), 72'd0);
    idle(1);

    // Aborted READ: MISO drops on the next edge, result kept valid
    pulse_done(R_A);
    idle(2);
    frame(8'hA0, 64'd0, 20, -1, 64'd0, cap, st_end);
    @(negedge SCK);
    check("abort_read_miso", 72'(MISO), 72'd0);
    idle(2);

    // 6: done mid-read keeps the new result
    frame(8'hA0, 64'd0, 72, 30, R_B, cap, st_end);
    check("t6_read_old", 72'(cap[63:0]), 72'(R_A));
    idle(2);
    frame(8'h50, 64'd0, 72, -1, 64'd0, cap, st_end);
    check("t6_status_rv", 72'(cap[63:56]), 72'h45);
    idle(2);
    frame(8'hA0, 64'd0, 72, -1, 64'd0, cap, st_end);
    check("t6_read_new", 72'(cap[63:0]), 72'(R_B));
    idle(2);
    frame(8'h50, 64'd0, 72, -1, 64'd0, cap, st_end);
    check("t6_status_cleared", 72'(cap[63:56]), 72'h05);
    idle(2);

    // done on the READ load edge
    frame(8'hA0, 64'd0, 72, 7, R_C, cap, st_end);
    check("t7_read_load_old", 72'(cap[63:0]), 72'(R_B));
    idle(2);
    frame(8'h50, 64'd0, 72, -1, 64'd0, cap, st_end);
    check("t7_status_rv", 72'(cap[63:56]), 72'h45);
    idle(2);
    frame(8'hA0, 64'd0, 72, -1, 64'd0, cap, st_end);
    check("t7_read_new", 72'(cap[63:0]), 72'(R_C));
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
